// File: rtl/red_pitaya_na_averager_block_pkg.sv
// Shared definitions for the network-analyser averager.
// Holds the FSM state encoding, register offsets and status bit positions.
package red_pitaya_na_averager_block_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLEEP = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] A_CTRL   = 16'h0000;
    localparam logic [15:0] A_AVG    = 16'h0004;
    localparam logic [15:0] A_SLEEP  = 16'h0008;
    localparam logic [15:0] A_STATUS = 16'h000C;
    localparam logic [15:0] A_RES    = 16'h0010;
    localparam logic [15:0] A_P_CH   = 16'h0200;
    localparam logic [15:0] A_P_IN   = 16'h0204;
    localparam logic [15:0] A_P_SUM  = 16'h0208;
    localparam logic [15:0] A_P_CNT  = 16'h020C;

    localparam int B_START = 0;
    localparam int B_ABORT = 1;

    localparam int S_STATE = 0;
    localparam int S_BUSY  = 2;
    localparam int S_DONE  = 3;
    localparam int S_OVF   = 8;

endpackage

// File: rtl/red_pitaya_na_averager_block_if.sv
// PS system bus: addr/wen/ren/wdata from the master,
// ack/rdata back from the slave register block.
interface red_pitaya_na_averager_block_if;

    logic [15:0] addr;
    logic        wen;
    logic        ren;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output addr, wen, ren, wdata,
        input  ack, rdata
    );

    modport slave (
        input  addr, wen, ren, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/red_pitaya_na_accumulator.sv
// One averager channel: sign-extend, accumulate, sticky overflow, result latch.
// Ports: clk_i/rstn_i, i_clear/i_add/i_latch controls, i_dat sample, o_res/o_ovf.
module red_pitaya_na_accumulator #(
    parameter int INBITS  = 24,
    parameter int SUMBITS = 62
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               i_clear,
    input  logic               i_add,
    input  logic               i_latch,
    input  logic [INBITS-1:0]  i_dat,
    output logic [SUMBITS-1:0] o_res,
    output logic               o_ovf
);

    logic [SUMBITS-1:0] w_ext;
    logic [SUMBITS-1:0] w_sum;
    logic [SUMBITS-1:0] r_acc;
    logic [SUMBITS-1:0] r_res;
    logic               r_ovf;
    logic               w_wrap;

    assign w_ext = {{(SUMBITS-INBITS){i_dat[INBITS-1]}}, i_dat};
    assign w_sum = r_acc + w_ext;

    // Same-sign operands giving a different-sign result means the add wrapped.
    assign w_wrap = (r_acc[SUMBITS-1] == w_ext[SUMBITS-1]) &&
                    (w_sum[SUMBITS-1] != r_acc[SUMBITS-1]);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_acc <= '0;
            r_res <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (i_clear) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (i_add) begin
                r_acc <= w_sum;
                r_ovf <= r_ovf | w_wrap;
            end
            // Latch with clear only happens for a zero-length run.
            if (i_latch) begin
                r_res <= i_clear ? '0 : w_sum;
            end
        end
    end

    assign o_res = r_res;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/red_pitaya_na_averager_block.sv
// Multi-channel averager: sleep, then sum a programmable number of samples.
// Ports: clk_i, rstn_i, trig_i, dat_i, busy_o, done_o, bus (PS system bus).
module red_pitaya_na_averager_block
    import red_pitaya_na_averager_block_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int INBITS   = 24,
    parameter int SUMBITS  = 62,
    parameter int CNTBITS  = 32
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         trig_i,
    input  logic [CHANNELS*INBITS-1:0]   dat_i,
    output logic                         busy_o,
    output logic                         done_o,
    red_pitaya_na_averager_block_if.slave bus
);

    state_t               r_state;
    state_t               w_next;
    logic [CNTBITS-1:0]   r_avg;
    logic [CNTBITS-1:0]   r_sleep;
    logic [CNTBITS-1:0]   r_avg_rem;
    logic [CNTBITS-1:0]   r_sleep_rem;
    logic                 w_ctrl_wr;
    logic                 w_start;
    logic                 w_abort;
    logic                 w_clear;
    logic                 w_add;
    logic                 w_latch;
    logic                 r_done;
    logic                 r_ack;
    logic [31:0]          r_rdata;
    logic [31:0]          w_rdata;
    logic [31:0]          w_status;
    logic [CHANNELS-1:0]  w_ovf;
    logic [SUMBITS-1:0]   w_res [CHANNELS];

    assign w_ctrl_wr = bus.wen && (bus.addr == A_CTRL);
    assign w_abort   = w_ctrl_wr && bus.wdata[B_ABORT];
    assign w_start   = trig_i || (w_ctrl_wr && bus.wdata[B_START]);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        w_add   = 1'b0;
        w_latch = 1'b0;
        if (w_abort) begin
            w_next = ST_IDLE;
        end else if (w_start) begin
            w_clear = 1'b1;
            if (r_avg == '0) begin
                w_next  = ST_DONE;
                w_latch = 1'b1;
            end else if (r_sleep == '0) begin
                w_next = ST_ACCUM;
            end else begin
                w_next = ST_SLEEP;
            end
        end else begin
            unique case (r_state)
                ST_SLEEP: begin
                    if (r_sleep_rem <= CNTBITS'(1)) begin
                        w_next = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    w_add = 1'b1;
                    if (r_avg_rem <= CNTBITS'(1)) begin
                        w_next  = ST_DONE;
                        w_latch = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_avg_rem   <= '0;
            r_sleep_rem <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_latch;
            if (w_clear) begin
                r_avg_rem   <= r_avg;
                r_sleep_rem <= r_sleep;
            end else begin
                if (r_state == ST_SLEEP) begin
                    r_sleep_rem <= r_sleep_rem - CNTBITS'(1);
                end
                if (w_add) begin
                    r_avg_rem <= r_avg_rem - CNTBITS'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        red_pitaya_na_accumulator #(
            .INBITS  (INBITS),
            .SUMBITS (SUMBITS)
        ) u_acc (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .i_clear (w_clear),
            .i_add   (w_add),
            .i_latch (w_latch),
            .i_dat   (dat_i[g*INBITS +: INBITS]),
            .o_res   (w_res[g]),
            .o_ovf   (w_ovf[g])
        );
    end

    assign busy_o = (r_state == ST_SLEEP) || (r_state == ST_ACCUM);
    assign done_o = r_done;

    always_comb begin
        w_status                        = '0;
        w_status[S_OVF +: CHANNELS]     = w_ovf;
        w_status[S_DONE]                = (r_state == ST_DONE);
        w_status[S_BUSY]                = busy_o;
        w_status[S_STATE +: 2]          = r_state;
    end

    always_comb begin
        w_rdata = '0;
        case (bus.addr)
            A_AVG:    w_rdata = 32'(r_avg);
            A_SLEEP:  w_rdata = 32'(r_sleep);
            A_STATUS: w_rdata = w_status;
            A_P_CH:   w_rdata = 32'(CHANNELS);
            A_P_IN:   w_rdata = 32'(INBITS);
            A_P_SUM:  w_rdata = 32'(SUMBITS);
            A_P_CNT:  w_rdata = 32'(CNTBITS);
            default:  ;
        endcase
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (bus.addr == A_RES + 16'(8 * ch)) begin
                w_rdata = w_res[ch][31:0];
            end
            if (bus.addr == A_RES + 16'(8 * ch + 4)) begin
                w_rdata = {{(64-SUMBITS){w_res[ch][SUMBITS-1]}},
                           w_res[ch][SUMBITS-1:32]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_avg   <= '0;
            r_sleep <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= bus.wen | bus.ren;
            if (bus.wen && (bus.addr == A_AVG)) begin
                r_avg <= CNTBITS'(bus.wdata);
            end
            if (bus.wen && (bus.addr == A_SLEEP)) begin
                r_sleep <= CNTBITS'(bus.wdata);
            end
            if (bus.ren) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign bus.ack   = r_ack;
    assign bus.rdata = r_rdata;

endmodule
